recon_frame_tx: RTL
===================

// Module: recon_frame_tx
// PURPOSE
// Transmit-side framer for the reconfiguration protocol. Takes a command (func_type, size_valid, addr, id, size)
// and an optional payload stream, and emits one AXI-Stream frame: a 46-byte Eth/IP/RMT header, then a 10-byte
// recon header at bytes 46..55, then the payload realigned to start at byte 56.
// Sits at the host/peer side and produces frames for the reconfiguration controller's ingress port.
// PARAMETERS
// DATA_WIDTH   512                  stream width in bits; only 512 is supported
// KEEP_WIDTH   DATA_WIDTH/8         tkeep width
// ADDR_WIDTH   34                   bitstream address width
// HDR_BYTES    46                   Eth/IP/RMT header length in bytes
// PORTS
// clk               in   1      clock
// rst               in   1      asynchronous reset, active-high
// eth_ip_hdr        in   368    static header template; byte k = bits [8k+7:8k]
// s_cmd_valid       in   1      command valid
// s_cmd_ready       out  1      command accepted when valid && ready
// s_cmd_func_type   in   2      00 = write, 01 = read
// s_cmd_size_valid  in   1      1 = header-only command frame; 0 = data frame, payload follows
// s_cmd_addr        in   34     bitstream address
// s_cmd_id          in   8      bitstream id
// s_cmd_size        in   32     bitstream size in bytes
// s_axis_tdata/tkeep/tvalid/tlast in, s_axis_tready out   payload input; tkeep is contiguous from bit 0
// m_axis_tdata/tkeep/tvalid/tlast out, m_axis_tready in   framed output
// tx_frame_count    out  32     frames completed (incremented on the beat with tlast), wraps
// BEHAVIOUR
// - Recon header, 80 bits, little-endian:
//   [1:0] func_type; [2] size_valid; [36:3] addr; [44:37] id; [76:45] size; [79:77] = 0.
// - Output stage is a single register ("slot"). Free = !m_axis_tvalid || m_axis_tready.
//   m_axis_tvalid stays high until the beat is taken. Data and keep are stable while valid is held.
// - s_cmd_ready  = (state==IDLE) && free.
// - s_axis_tready = (state==HDR || state==PAYLOAD) && free. In FLUSH it is 0.
// - Latency: an accepted input (command or payload) beat appears at m_axis one cycle later.
// - Residual register holds input bytes 8..63 of the last accepted payload beat, plus their keep (56 bits).
// - IDLE, command accepted:
//   - size_valid=1: load one beat = template | recon header, tkeep = 56 low ones, tlast = 1; stay in IDLE.
//   - size_valid=0: latch all fields, go to HDR.
// - HDR, payload beat P accepted: out = template | recon header | P[63:0] at bytes 56..63.
//   tkeep = 56 ones | P.tkeep[7:0] << 56.
// - PAYLOAD, beat P accepted: out = residual | P[63:0] << 448. tkeep built the same way. Residual <= P bytes 8..63.
// - On P.tlast, in HDR or PAYLOAD:
//   - P.tkeep[63:8]==0: the output beat carries tlast, go to IDLE.
//   - otherwise: that beat has no tlast, go to FLUSH.
//   Without P.tlast: HDR goes to PAYLOAD, PAYLOAD stays in PAYLOAD.
// - FLUSH, when free: out = residual with tkeep = residual keep, tlast = 1; go to IDLE.
// - A frame is never interleaved with another command. Payload beats seen in IDLE are not accepted.
// - Simultaneous accept and drain of the slot in the same cycle is legal (full throughput, 1 beat/cycle).
// - Reset (async) values:
//   - state = IDLE
//   - m_axis_tvalid = 0; m_axis_tdata, m_axis_tkeep, m_axis_tlast, residual = 0
//   - tx_frame_count = 0
//   - s_cmd_ready and s_axis_tready are 0 while rst is high
// - Reset mid-frame abandons the frame with no tlast; the downstream frame FIFO drops it.
// - An all-zero-keep payload beat is illegal input; the block does not check for it.
// TESTING
// 1 Cmd func=01, sv=1, addr=0x1_0000_0000, id=5, size=0x1000
//   -> one beat, tkeep=0x00FF_FFFF_FFFF_FFFF, tlast=1.
//   Bits 368..447 = {3'b0, 32'h1000, 8'h05, 34'h1_0000_0000, 1'b1, 2'b01}. tx_frame_count=1.
// 2 Cmd sv=0, one 8-byte payload beat (tkeep=0xFF, tlast)
//   -> one beat, tkeep=all ones, tlast=1, bytes 56..63 = payload.
// 3 Cmd sv=0, 64-byte payload (one full beat, tlast)
//   -> beat0 full keep, no last; beat1 = payload bytes 8..63, tkeep=0x00FF_FFFF_FFFF_FFFF, tlast.
// 4 Cmd sv=0, 120-byte payload (full beat, then a beat with tkeep=0x00FF_FFFF_FFFF_FFFF, tlast)
//   -> 3 beats, keeps = full, full, 0x0000_FFFF_FFFF_FFFF; byte stream = header + payload 0..119.
// 5 Test 4 with m_axis_tready toggled randomly (50%)
//   -> identical beats; no loss or duplication; s_axis_tready low whenever the slot is held.
// 6 Assert rst during beat 1 of test 4, then run test 1
//   -> outputs zero immediately, count=0; the next frame is correct, count=1.

Source files
------------

// File: rtl/recon_frame_tx.sv
// Reconfiguration-protocol TX framer: prepends Eth/IP/RMT + 10-byte recon header and realigns payload by 56 bytes.
// One-cycle latency through a single output slot; inputs stall whenever the slot is held.
module recon_frame_tx #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 34,
  parameter int HDR_BYTES  = 46
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [HDR_BYTES*8-1:0]  eth_ip_hdr,
  input  logic                    s_cmd_valid,
  output logic                    s_cmd_ready,
  input  logic [1:0]              s_cmd_func_type,
  input  logic                    s_cmd_size_valid,
  input  logic [ADDR_WIDTH-1:0]   s_cmd_addr,
  input  logic [7:0]              s_cmd_id,
  input  logic [31:0]             s_cmd_size,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [31:0]             tx_frame_count
);

  localparam int RES_W   = DATA_WIDTH - 64;
  localparam int RES_K   = KEEP_WIDTH - 8;
  localparam int RECON_W = 80;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, FLUSH} state_t;

  state_t                state_q;
  logic [RECON_W-1:0]    recon_q;
  logic [RES_W-1:0]      resid_dat_q;
  logic [RES_K-1:0]      resid_keep_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [31:0]           count_q;

  logic                  free;
  logic                  cmd_fire;
  logic                  pay_fire;
  logic                  pay_end;
  logic [RECON_W-1:0]    recon_d;
  logic [RES_W-1:0]      lead_dat;
  logic [RES_K-1:0]      lead_keep;

  assign free          = !tvalid_q || m_axis_tready;
  assign s_cmd_ready   = !rst && (state_q == IDLE) && free;
  assign s_axis_tready = !rst && ((state_q == HDR) || (state_q == PAYLOAD)) && free;
  assign cmd_fire      = s_cmd_valid && s_cmd_ready;
  assign pay_fire      = s_axis_tvalid && s_axis_tready;

  assign recon_d = {3'b000, s_cmd_size, s_cmd_id, s_cmd_addr, s_cmd_size_valid, s_cmd_func_type};

  // The low 56 bytes of every payload-carrying beat are either the full header
  // (first beat) or the 56 bytes left over from the previous input beat.
  assign lead_dat  = (state_q == HDR) ? {recon_q, eth_ip_hdr} : resid_dat_q;
  assign lead_keep = (state_q == HDR) ? {RES_K{1'b1}} : resid_keep_q;
  assign pay_end   = s_axis_tlast && (s_axis_tkeep[KEEP_WIDTH-1:8] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      recon_q      <= '0;
      resid_dat_q  <= '0;
      resid_keep_q <= '0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      if (tvalid_q && m_axis_tready && tlast_q) count_q <= count_q + 32'd1;
      if (free) tvalid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (s_cmd_size_valid) begin
              tdata_q  <= {64'b0, recon_d, eth_ip_hdr};
              tkeep_q  <= {8'b0, {RES_K{1'b1}}};
              tlast_q  <= 1'b1;
              tvalid_q <= 1'b1;
            end else begin
              recon_q <= recon_d;
              state_q <= HDR;
            end
          end
        end
        HDR, PAYLOAD: begin
          if (pay_fire) begin
            tdata_q      <= {s_axis_tdata[63:0], lead_dat};
            tkeep_q      <= {s_axis_tkeep[7:0], lead_keep};
            tlast_q      <= pay_end;
            tvalid_q     <= 1'b1;
            resid_dat_q  <= s_axis_tdata[DATA_WIDTH-1:64];
            resid_keep_q <= s_axis_tkeep[KEEP_WIDTH-1:8];
            if (s_axis_tlast) state_q <= pay_end ? IDLE : FLUSH;
            else              state_q <= PAYLOAD;
          end
        end
        FLUSH: begin
          if (free) begin
            tdata_q  <= {64'b0, resid_dat_q};
            tkeep_q  <= {8'b0, resid_keep_q};
            tlast_q  <= 1'b1;
            tvalid_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata   = tdata_q;
  assign m_axis_tkeep   = tkeep_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign tx_frame_count = count_q;

endmodule
